sixty_four_bit_sign_narrower: RTL
=================================

# sixty_four_bit_sign_narrower

Store-path narrowing unit for the LEGv8 datapath. It takes a 64-bit register value and packs it into a byte, half, word or double field for STURB/STURH/STURW/STUR. It reverses the sign extension done on the load path and flags any value that does not fit the target field. The unit sits between register read and the data-memory write port, with a one-entry pipeline register and a skid buffer behind valid/ready handshakes.

## Interface
- `CNT_W`, default 16: width of the overflow event counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit can accept a request.
- `in_data` input 64: source register value.
- `in_size` input 2: 00 byte, 01 half, 10 word, 11 double.
- `in_signed` input 1: 1 means two's-complement range check, 0 means unsigned.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output 64: narrowed value in bits [N-1:0], upper bits zero.
- `out_ovf` output 1: source value not representable in N bits.
- `ovf_cnt` output `CNT_W`: count of overflowed results delivered.
- `cnt_clr` input 1: synchronous clear of `ovf_cnt`.

## Operation
- N = 8, 16, 32 or 64 according to `in_size`.
- Signed overflow: `in_data[63:N-1]` not all equal.
- Unsigned overflow: `in_data[63:N]` not all zero.
- Size 11 never overflows. `out_data` equals `in_data`.
- No overflow: `out_data` = `in_data[N-1:0]`, zero-padded.
- Overflow: the field is either truncated or saturated (see Configuration). `out_ovf` is set in both cases.
- Input handshake completes when `in_valid && in_ready`. Output handshake completes when `out_valid && out_ready`.
- Results are computed at input acceptance and stored with their flag. Results leave in acceptance order.
- Storage is an output register plus one skid entry. States: EMPTY, ONE (output register full), FULL (output register and skid both full).
  - EMPTY to ONE on accept.
  - ONE to FULL on accept without drain.
  - ONE to EMPTY on drain without accept.
  - FULL to ONE on drain; the skid entry moves to the output register.
  - ONE with accept and drain in the same cycle stays in ONE.
- `in_ready` is 1 exactly when the state is not FULL. It is driven from registered state only.
- `ovf_cnt` increments on each output handshake with `out_ovf` = 1. It saturates at all ones.
- `cnt_clr` has priority over a same-cycle increment; the counter becomes 0.

## Timing
- Latency: a request accepted in cycle n is presented with `out_valid` = 1 in cycle n+1.
- Throughput is one result per cycle while `out_ready` stays 1.
- `out_data`, `out_ovf` and `out_valid` hold stable while `out_valid && !out_ready`.
- Reset values: `out_valid` 0, `out_data` 0, `out_ovf` 0, `ovf_cnt` 0, state EMPTY.
- `in_ready` is 0 while `rst_n` is low and 1 in the first cycle after release.
- Reset mid-operation discards both entries immediately. No partial result is delivered.

## Configuration
- Macro `SIGN_NARROWER_SAT_EN`.
- Defined: overflowed results saturate.
  - Signed: positive source gives max positive (e.g. byte 0x7F); negative source gives min negative (byte 0x80).
  - Unsigned: all ones in N bits.
- Undefined: overflowed results are truncated to `in_data[N-1:0]`.
- `out_ovf` and `ovf_cnt` behave identically either way.

## Structure
- Shared package `legv8_pkg`:
  - size encoding constants `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, `SZ_DOUBLE`.
  - `narrow_res_t` struct holding data and ovf.
- Sub-module `narrow_calc`: combinational range check and truncate/saturate, instantiated once on the input side. The handshake, storage and counter stay in the top module.

## Test plan
- Byte, signed, `in_data` = 0xFFFF_FFFF_FFFF_FFF4 -> `out_data` = 0xF4, `out_ovf` = 0, one cycle later.
- Byte, signed, `in_data` = 0x80 -> `out_ovf` = 1. `out_data` = 0x80 with the macro undefined, 0x7F with it defined. `ovf_cnt` = 1 after the handshake.
- Half, unsigned, `in_data` = 0x1_0000 -> `out_ovf` = 1. `out_data` = 0x0000 (truncate) or 0xFFFF (saturate).
- Backpressure: hold `out_ready` = 0, offer 3 back-to-back requests -> 2 accepted and `in_ready` drops. Release `out_ready` -> results arrive in order with no loss or duplication.
- Counter: with `CNT_W` = 4, deliver 17 overflow results -> `ovf_cnt` = 0xF. Assert `cnt_clr` together with an overflow delivery -> 0.
- Assert `rst_n` low in state FULL -> `out_valid` = 0 at once. After release, `in_ready` = 1 and the next request completes normally.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 store-path definitions: size encodings, narrowed-result record
// and the occupancy states of the narrower's output buffer.
package legv8_pkg;

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  typedef struct packed {
    logic [63:0] data;
    logic        ovf;
  } narrow_res_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } buf_state_t;

endpackage

// File: rtl/narrow_calc.sv
// Combinational range check and narrowing of a 64-bit value to byte/half/word/double.
// Macro SIGN_NARROWER_SAT_EN selects saturation of overflowed results; otherwise truncation.
module narrow_calc
  import legv8_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  size,
  input  logic        sgn,
  output narrow_res_t res
);

  logic [3:0]  ovf_vec;
  logic [63:0] trunc_vec [4];
`ifdef SIGN_NARROWER_SAT_EN
  logic [63:0] sat_vec [4];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_size
      localparam int N = 8 << gi;
      if (N == 64) begin : g_dbl
        assign ovf_vec[gi]   = 1'b0;
        assign trunc_vec[gi] = data;
`ifdef SIGN_NARROWER_SAT_EN
        assign sat_vec[gi]   = data;
`endif
      end else begin : g_nar
        // Signed fit: every bit from the field's sign bit upward must agree.
        logic [64-N:0] hi_s;
        logic          ovf_s;
        logic          ovf_u;
        assign hi_s  = data[63:N-1];
        assign ovf_s = !((&hi_s) || !(|hi_s));
        assign ovf_u = |data[63:N];
        assign ovf_vec[gi]   = sgn ? ovf_s : ovf_u;
        assign trunc_vec[gi] = {{(64-N){1'b0}}, data[N-1:0]};
`ifdef SIGN_NARROWER_SAT_EN
        localparam logic [63:0] UMAX = (64'd1 << N) - 64'd1;
        localparam logic [63:0] SMAX = (64'd1 << (N-1)) - 64'd1;
        localparam logic [63:0] SMIN = 64'd1 << (N-1);
        assign sat_vec[gi] = !sgn ? UMAX : (data[63] ? SMIN : SMAX);
`endif
      end
    end
  endgenerate

  always_comb begin
    logic [1:0] idx;
    idx = 2'd3;
    unique case (size)
      SZ_BYTE:   idx = 2'd0;
      SZ_HALF:   idx = 2'd1;
      SZ_WORD:   idx = 2'd2;
      SZ_DOUBLE: idx = 2'd3;
      default:   idx = 2'd3;
    endcase
    res.ovf = ovf_vec[idx];
`ifdef SIGN_NARROWER_SAT_EN
    res.data = ovf_vec[idx] ? sat_vec[idx] : trunc_vec[idx];
`else
    res.data = trunc_vec[idx];
`endif
  end

endmodule

// File: rtl/sixty_four_bit_sign_narrower.sv
// Store-path narrower: narrow_calc on the input, output register plus skid entry,
// and a saturating overflow counter. Build option: SIGN_NARROWER_SAT_EN (saturate).
module sixty_four_bit_sign_narrower
  import legv8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [1:0]       in_size,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  buf_state_t  state_reg, state_next;
  narrow_res_t out_reg, out_next;
  narrow_res_t skid_reg, skid_next;
  narrow_res_t calc_res;
  logic        ready_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic accept;
  logic drain;

  narrow_calc u_calc (
    .data (in_data),
    .size (in_size),
    .sgn  (in_signed),
    .res  (calc_res)
  );

  assign accept = in_valid && ready_reg;
  assign drain  = (state_reg != ST_EMPTY) && out_ready;

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    skid_next  = skid_reg;
    unique case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          out_next   = calc_res;
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          out_next = calc_res;
        end else if (accept) begin
          skid_next  = calc_res;
          state_next = ST_FULL;
        end else if (drain) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Input is stalled here, so only a drain can change occupancy.
        if (drain) begin
          out_next   = skid_reg;
          state_next = ST_ONE;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      out_reg   <= '0;
      skid_reg  <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      skid_reg  <= skid_next;
      ready_reg <= (state_next != ST_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (cnt_clr) begin
      cnt_reg <= '0;
    end else if (drain && out_reg.ovf && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = (state_reg != ST_EMPTY);
  assign out_data  = out_reg.data;
  assign out_ovf   = out_reg.ovf;
  assign ovf_cnt   = cnt_reg;

endmodule
